// File: rtl/nco_clkgen.sv
// Multi-channel NCO clock-enable generator: each channel emits carry-out pulses of a
// phase accumulator plus a divide-by-two square wave, gated by a PLL-style lock timer.
module nco_clkgen #(
    parameter int NUM_CH      = 2,
    parameter int ACC_W       = 32,
    parameter int LOCK_CYCLES = 1024
) (
    input  logic                    refclk,
    input  logic                    rst_n,
    input  logic [NUM_CH*ACC_W-1:0] inc_i,
    input  logic                    load,
    input  logic                    hold,
    output logic [NUM_CH-1:0]       ce_o,
    output logic [NUM_CH-1:0]       clk_o,
    output logic                    locked
);

    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    typedef enum logic {
        SETTLE,
        LOCKED
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               locked_reg;

    logic [ACC_W-1:0]   inc_reg [NUM_CH];
    logic [ACC_W-1:0]   acc_reg [NUM_CH];
    logic [ACC_W:0]     sum     [NUM_CH];
    logic [NUM_CH-1:0]  ce_reg;
    logic [NUM_CH-1:0]  clk_reg;

    assign ce_o   = ce_reg;
    assign clk_o  = clk_reg;
    assign locked = locked_reg;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            sum[k] = {1'b0, acc_reg[k]} + {1'b0, inc_reg[k]};
        end
    end

    // Lock timer: counts edges in SETTLE, locks on the edge cnt reaches LOCK_CYCLES.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= SETTLE;
            cnt_reg    <= '0;
            locked_reg <= 1'b0;
        end else if (load) begin
            state_reg  <= SETTLE;
            cnt_reg    <= '0;
            locked_reg <= 1'b0;
        end else begin
            case (state_reg)
                SETTLE: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_LAST) begin
                        state_reg  <= LOCKED;
                        locked_reg <= 1'b1;
                    end
                end
                LOCKED: begin
                    cnt_reg <= cnt_reg;
                end
                default: begin
                    state_reg <= SETTLE;
                end
            endcase
        end
    end

    // Accumulation uses the registered lock flag, so the first step lands one edge after lock.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                inc_reg[k] <= '0;
                acc_reg[k] <= '0;
            end
            ce_reg  <= '0;
            clk_reg <= '0;
        end else if (load) begin
            for (int k = 0; k < NUM_CH; k++) begin
                inc_reg[k] <= inc_i[k*ACC_W +: ACC_W];
                acc_reg[k] <= '0;
            end
            ce_reg  <= '0;
            clk_reg <= '0;
        end else if (locked_reg && !hold) begin
            for (int k = 0; k < NUM_CH; k++) begin
                acc_reg[k] <= sum[k][ACC_W-1:0];
                ce_reg[k]  <= sum[k][ACC_W];
                if (sum[k][ACC_W]) begin
                    clk_reg[k] <= ~clk_reg[k];
                end
            end
        end else begin
            ce_reg <= '0;
        end
    end

endmodule

// File: tb/tb_nco_clkgen.sv
// Randomised bench for nco_clkgen with a closed-form reference: pulses after s
// accumulate steps are floor(s*inc / 2^ACC_W), clk_o is that count's parity.
module tb_nco_clkgen;

    localparam int NUM_CH      = 2;
    localparam int ACC_W       = 8;
    localparam int LOCK_CYCLES = 4;

    logic                    refclk;
    logic                    rst_n;
    logic [NUM_CH*ACC_W-1:0] inc_i;
    logic                    load;
    logic                    hold;
    logic [NUM_CH-1:0]       ce_o;
    logic [NUM_CH-1:0]       clk_o;
    logic                    locked;

    nco_clkgen #(
        .NUM_CH(NUM_CH),
        .ACC_W(ACC_W),
        .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .refclk(refclk),
        .rst_n(rst_n),
        .inc_i(inc_i),
        .load(load),
        .hold(hold),
        .ce_o(ce_o),
        .clk_o(clk_o),
        .locked(locked)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: edges since last load/reset, steps taken, loaded increments.
    longint unsigned m_edges;
    longint unsigned m_steps [NUM_CH];
    longint unsigned m_inc   [NUM_CH];
    logic            m_ce    [NUM_CH];

    function automatic longint unsigned pulses(input longint unsigned s, input longint unsigned inc);
        return (s * inc) >> ACC_W;
    endfunction

    initial begin
        m_edges = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            m_steps[k] = 0;
            m_inc[k]   = 0;
            m_ce[k]    = 1'b0;
        end
        forever begin
            @(posedge refclk);
            if (!rst_n) begin
                m_edges = 0;
                for (int k = 0; k < NUM_CH; k++) begin
                    m_steps[k] = 0;
                    m_inc[k]   = 0;
                    m_ce[k]    = 1'b0;
                end
            end else if (load) begin
                m_edges = 0;
                for (int k = 0; k < NUM_CH; k++) begin
                    m_steps[k] = 0;
                    m_inc[k]   = longint'(inc_i[k*ACC_W +: ACC_W]);
                    m_ce[k]    = 1'b0;
                end
            end else begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (m_edges >= LOCK_CYCLES && !hold) begin
                        m_steps[k] = m_steps[k] + 1;
                        m_ce[k] = (pulses(m_steps[k], m_inc[k]) != pulses(m_steps[k] - 1, m_inc[k]));
                    end else begin
                        m_ce[k] = 1'b0;
                    end
                end
                if (m_edges < LOCK_CYCLES) m_edges = m_edges + 1;
            end
            #1;
            chk("locked", longint'(locked), longint'(m_edges >= LOCK_CYCLES));
            for (int k = 0; k < NUM_CH; k++) begin
                chk($sformatf("ce_o[%0d]", k), longint'(ce_o[k]), longint'(m_ce[k]));
                chk($sformatf("clk_o[%0d]", k), longint'(clk_o[k]),
                    longint'(pulses(m_steps[k], m_inc[k]) & 1));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge refclk);
    endtask

    task automatic do_load(input logic [ACC_W-1:0] i0, input logic [ACC_W-1:0] i1);
        inc_i = {i1, i0};
        load  = 1'b1;
        cyc(1);
        load  = 1'b0;
    endtask

    int cnt0, cnt1;

    initial begin
        rst_n = 1'b0;
        inc_i = '0;
        load  = 1'b0;
        hold  = 1'b0;
        cyc(2);
        chk("reset_locked", longint'(locked), 0);
        chk("reset_ce", longint'(ce_o), 0);
        rst_n = 1'b1;
        cyc(3);
        chk("rst_lock_edge3", longint'(locked), 0);
        cyc(1);
        chk("rst_lock_edge4", longint'(locked), 1);

        // Lock timing and first pulses with inc=0x80
        do_load(8'h80, 8'h80);
        cyc(3);
        chk("t1_locked_e3", longint'(locked), 0);
        cyc(1);
        chk("t1_locked_L", longint'(locked), 1);
        cyc(1);
        chk("t1_ce_L1", longint'(ce_o[0]), 0);
        cyc(1);
        chk("t1_ce_L2", longint'(ce_o[0]), 1);
        chk("t1_clk_L2", longint'(clk_o[0]), 1);
        cyc(1);
        chk("t1_ce_L3", longint'(ce_o[0]), 0);
        cyc(1);
        chk("t1_ce_L4", longint'(ce_o[0]), 1);
        chk("t1_clk_L4", longint'(clk_o[0]), 0);

        // Rate over 768 locked cycles
        do_load(8'h40, 8'h55);
        cyc(4);
        cnt0 = 0;
        cnt1 = 0;
        repeat (768) begin
            cyc(1);
            cnt0 += int'(ce_o[0]);
            cnt1 += int'(ce_o[1]);
        end
        chk("rate_ch0", cnt0, 192);
        chk("rate_ch1", cnt1, 255);

        // Reload mid-run
        do_load(8'h20, 8'h20);
        chk("reload_locked", longint'(locked), 0);
        chk("reload_ce", longint'(ce_o), 0);
        chk("reload_clk", longint'(clk_o), 0);
        chk("reload_acc", longint'(dut.acc_reg[0]), 0);
        cyc(4);
        chk("reload_relock", longint'(locked), 1);
        cnt0 = 0;
        repeat (64) begin
            cyc(1);
            cnt0 += int'(ce_o[0]);
        end
        chk("reload_rate", cnt0, 8);

        // Hold with acc at 0x80
        do_load(8'h80, 8'h80);
        cyc(5);
        chk("hold_acc_pre", longint'(dut.acc_reg[0]), 128);
        hold = 1'b1;
        repeat (10) begin
            cyc(1);
            chk("hold_ce", longint'(ce_o), 0);
        end
        chk("hold_acc", longint'(dut.acc_reg[0]), 128);
        hold = 1'b0;
        cyc(1);
        chk("hold_resume_ce", longint'(ce_o[0]), 1);

        // load together with hold
        hold = 1'b1;
        do_load(8'h10, 8'h10);
        chk("loadhold_locked", longint'(locked), 0);
        chk("loadhold_clk", longint'(clk_o), 0);
        hold = 1'b0;

        // load during SETTLE at cnt=2
        cyc(2);
        do_load(8'h10, 8'h10);
        cyc(3);
        chk("settle_reload_e3", longint'(locked), 0);
        cyc(1);
        chk("settle_reload_e4", longint'(locked), 1);

        // inc=0 gives no pulses
        do_load(8'h00, 8'h00);
        cyc(4);
        cnt0 = 0;
        repeat (1000) begin
            cyc(1);
            cnt0 += int'(ce_o[0]) + int'(ce_o[1]);
        end
        chk("zero_inc_pulses", cnt0, 0);

        // Randomised traffic checked by the per-cycle model
        for (int it = 0; it < 30; it++) begin
            logic [ACC_W-1:0] r0, r1;
            int sel;
            sel = $urandom_range(0, 5);
            r0 = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : (sel == 2) ? 8'h80 : 8'($urandom_range(0, 255));
            r1 = 8'($urandom_range(0, 255));
            do_load(r0, r1);
            repeat ($urandom_range(10, 200)) begin
                hold = ($urandom_range(0, 4) == 0);
                if ($urandom_range(0, 99) == 0) begin
                    inc_i = 16'($urandom_range(0, 65535));
                    load  = 1'b1;
                end
                cyc(1);
                load = 1'b0;
            end
            hold = 1'b0;
        end

        // Asynchronous reset mid-run
        do_load(8'hFF, 8'h81);
        cyc(6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_locked", longint'(locked), 0);
        chk("async_ce", longint'(ce_o), 0);
        chk("async_clk", longint'(clk_o), 0);
        @(negedge refclk);
        rst_n = 1'b1;
        cyc(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
